// File: rtl/serial_word_feeder_pkg.sv
// Shared types and default sizing for the serial word feeder.
package serial_word_feeder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } fsm_state_t;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Word input handshake and serial output bundle of the feeder.
interface serial_word_feeder_if
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, busy
  );
endinterface

// File: rtl/serial_word_feeder_word_fifo.sv
// Word buffer for the feeder: circular FIFO with registered occupancy count.
module word_fifo
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/serial_word_feeder.sv
// Buffers parallel words and shifts them out MSB first as a gapless bit stream.
// state | meaning
// IDLE  | nothing to send; sout held at 0
// SHIFT | shift register driving one payload bit per cycle
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic                clk,
  input logic                reset,
  serial_word_feeder_if.slave bus
);
  localparam int CW = count_width(DEPTH);
  localparam int BW = $clog2(WIDTH);

  fsm_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign bus.din_ready  = (count < CW'(DEPTH));
  assign push           = bus.din_valid && bus.din_ready;
  assign bus.sout       = shreg_q[WIDTH-1];
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.busy       = (count != '0) || (state_q == SHIFT);

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (bus.din),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shreg_d = head;
          bit_d   = BW'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_q == '0) begin
          if (count != '0) begin
            pop     = 1'b1;
            shreg_d = head;
            bit_d   = BW'(WIDTH - 1);
          end else begin
            // Clearing here keeps sout low throughout IDLE.
            shreg_d = '0;
            state_d = IDLE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q - BW'(1);
        end
      end
      default: begin
        shreg_d = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: vector table plus reset/full corner sequences.
module tb_serial_word_feeder;
  logic clk = 1'b0;
  logic reset = 1'b0;

  serial_word_feeder_if #(.WIDTH(8)) if8 ();
  serial_word_feeder_if #(.WIDTH(4)) if4 ();

  serial_word_feeder #(.WIDTH(8), .DEPTH(4)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  serial_word_feeder #(.WIDTH(4), .DEPTH(2)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    bit         rst;
    bit         dv;
    logic [7:0] din;
    bit         rdy;
    bit         so;
    bit         sv;
    bit         bz;
  } vec_t;

  vec_t vecs[$];
  logic rx_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void add(bit sel, bit rst, bit dv, logic [7:0] din,
                              bit rdy, bit so, bit sv, bit bz);
    vec_t v;
    v.sel = sel; v.rst = rst; v.dv = dv; v.din = din;
    v.rdy = rdy; v.so = so; v.sv = sv; v.bz = bz;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_rx();
    step();
    if (if8.sout_valid) rx_q.push_back(if8.sout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a, f0, f1, cw, got;
    logic [7:0] w [6];
    logic [7:0] ld [6];
    bit dv, rdy, sv, so;
    logic [7:0] din;

    if8.din_valid = 1'b0; if8.din = '0;
    if4.din_valid = 1'b0; if4.din = '0;
    step(); step();
    chk("rst_ready", 32'(if8.din_ready), 32'd1);
    chk("rst_sout",  32'(if8.sout), 32'd0);
    chk("rst_valid", 32'(if8.sout_valid), 32'd0);
    chk("rst_busy",  32'(if8.busy), 32'd0);

    // single word 8'hE0
    a = 8'hE0;
    add(0, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 1, 1, a, 1, 0, 0, 1);
    for (int i = 7; i >= 0; i--) add(0, 1, 0, 8'h00, 1, a[i], 1, 1);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0);

    // two back-to-back words, no gap
    f0 = 8'hF0; f1 = 8'h0F;
    add(0, 1, 1, f0, 1, 0, 0, 1);
    add(0, 1, 1, f1, 1, f0[7], 1, 1);
    for (int i = 6; i >= 0; i--) add(0, 1, 0, 8'h00, 1, f0[i], 1, 1);
    for (int i = 7; i >= 0; i--) add(0, 1, 0, 8'h00, 1, f1[i], 1, 1);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0);

    // din_valid held high with six words: buffer fills, ready drops and returns
    w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'h81; w[3] = 8'h7E; w[4] = 8'hC3; w[5] = 8'h96;
    add(0, 0, 0, 8'h00, 1, 0, 0, 0);
    for (int k = 1; k <= 50; k++) begin
      dv  = (k <= 11);
      din = (k <= 5) ? w[k-1] : (k <= 11 ? w[5] : 8'h00);
      rdy = !((k >= 5 && k <= 9) || (k >= 11 && k <= 17));
      sv  = (k >= 2 && k <= 49);
      so  = 1'b0;
      if (sv) begin
        cw = w[(k-2)/8];
        so = cw[7 - ((k-2) % 8)];
      end
      add(0, 1, dv, din, rdy, so, sv, (k <= 49));
    end

    // WIDTH=4, DEPTH=2 instance
    add(1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 1, 1, 8'h0E, 1, 0, 0, 1);
    add(1, 1, 0, 8'h00, 1, 1, 1, 1);
    add(1, 1, 0, 8'h00, 1, 1, 1, 1);
    add(1, 1, 0, 8'h00, 1, 1, 1, 1);
    add(1, 1, 0, 8'h00, 1, 0, 1, 1);
    add(1, 1, 0, 8'h00, 1, 0, 0, 0);
    add(1, 1, 1, 8'h09, 1, 0, 0, 1);
    add(1, 1, 1, 8'h06, 1, 1, 1, 1);
    add(1, 1, 1, 8'h03, 0, 0, 1, 1);
    add(1, 1, 0, 8'h00, 0, 0, 1, 1);
    add(1, 1, 0, 8'h00, 0, 1, 1, 1);
    add(1, 1, 0, 8'h00, 1, 0, 1, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      if (vecs[i].sel == 1'b0) begin
        if8.din_valid = vecs[i].dv; if8.din = vecs[i].din; if4.din_valid = 1'b0;
      end else begin
        if4.din_valid = vecs[i].dv; if4.din = vecs[i].din[3:0]; if8.din_valid = 1'b0;
      end
      step();
      if (vecs[i].sel == 1'b0) begin
        chk($sformatf("vec%0d ready", i), 32'(if8.din_ready), 32'(vecs[i].rdy));
        chk($sformatf("vec%0d sout", i), 32'(if8.sout), 32'(vecs[i].so));
        chk($sformatf("vec%0d valid", i), 32'(if8.sout_valid), 32'(vecs[i].sv));
        chk($sformatf("vec%0d busy", i), 32'(if8.busy), 32'(vecs[i].bz));
      end else begin
        chk($sformatf("vec%0d w4 ready", i), 32'(if4.din_ready), 32'(vecs[i].rdy));
        chk($sformatf("vec%0d w4 sout", i), 32'(if4.sout), 32'(vecs[i].so));
        chk($sformatf("vec%0d w4 valid", i), 32'(if4.sout_valid), 32'(vecs[i].sv));
        chk($sformatf("vec%0d w4 busy", i), 32'(if4.busy), 32'(vecs[i].bz));
      end
    end
    if4.din_valid = 1'b0;

    // push and pop on the same edge with three words buffered
    ld[0] = 8'h12; ld[1] = 8'h34; ld[2] = 8'h56; ld[3] = 8'h78; ld[4] = 8'h9A; ld[5] = 8'hBC;
    reset = 1'b0; if8.din_valid = 1'b0; step(); reset = 1'b1;
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      if8.din_valid = 1'b1; if8.din = ld[i]; step_rx();
    end
    if8.din_valid = 1'b0;
    repeat (5) step_rx();
    chk("pp_pre_ready", 32'(if8.din_ready), 32'd1);
    if8.din_valid = 1'b1; if8.din = ld[4]; step_rx();
    chk("pp_same_edge_ready", 32'(if8.din_ready), 32'd1);
    if8.din = ld[5]; step_rx();
    chk("pp_full_ready", 32'(if8.din_ready), 32'd0);
    if8.din_valid = 1'b0;
    repeat (45) step_rx();
    chk("pp_bit_count", 32'(rx_q.size()), 32'd48);
    if (rx_q.size() == 48) begin
      for (int wi = 0; wi < 6; wi++) begin
        for (int b = 0; b < 8; b++) got[7-b] = rx_q[wi*8 + b];
        chk($sformatf("pp_word%0d", wi), 32'(got), 32'(ld[wi]));
      end
    end
    chk("pp_end_busy", 32'(if8.busy), 32'd0);

    // reset in the middle of a word flushes everything
    reset = 1'b0; step(); reset = 1'b1;
    rx_q.delete();
    if8.din_valid = 1'b1; if8.din = 8'hFF; step_rx();
    if8.din = 8'h55; step_rx();
    if8.din_valid = 1'b0;
    step_rx(); step_rx();
    chk("mid_partial_bits", 32'(rx_q.size()), 32'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_sout", 32'(if8.sout), 32'd0);
    chk("mid_rst_valid", 32'(if8.sout_valid), 32'd0);
    chk("mid_rst_busy", 32'(if8.busy), 32'd0);
    step();
    reset = 1'b1;
    rx_q.delete();
    if8.din_valid = 1'b1; if8.din = 8'h81; step_rx();
    if8.din_valid = 1'b0;
    repeat (15) step_rx();
    chk("post_rst_bit_count", 32'(rx_q.size()), 32'd8);
    if (rx_q.size() == 8) begin
      for (int b = 0; b < 8; b++) got[7-b] = rx_q[b];
      chk("post_rst_word", 32'(got), 32'h81);
    end
    chk("post_rst_busy", 32'(if8.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
